// File: rtl/fp_stream_adapter.sv
// fp_stream_adapter: valid/ready front end for a fixed-latency, non-stallable
// FloPoCo operator core. Operands go straight to the core. A Latency-deep
// valid pipe marks the cycle in which each result appears. Results are then
// captured into a credit-guarded FIFO, so downstream backpressure never drops
// a result.
// Optional feature: define FP_STREAM_ADAPTER_FLUSH_EN to add a synchronous
// flush_i input that discards every in-flight and buffered operation.
module fp_stream_adapter #(
    parameter int DataWidth = 34,
    parameter int Latency   = 2,
    parameter int BufDepth  = Latency + 2
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
`ifdef FP_STREAM_ADAPTER_FLUSH_EN
    input  logic                 flush_i,
`endif
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [DataWidth-1:0] in_data_i,
    output logic [DataWidth-1:0] core_operand_o,
    input  logic [DataWidth-1:0] core_result_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [DataWidth-1:0] out_data_o,
    output logic                 busy_o
);

    localparam int CntW = $clog2(BufDepth + 1);
    localparam int PtrW = (BufDepth > 1) ? $clog2(BufDepth) : 1;
    localparam logic [CntW-1:0] DepthCnt = CntW'(BufDepth);
    localparam logic [PtrW-1:0] LastPtr  = PtrW'(BufDepth - 1);

    logic                 flush;
    logic [Latency-1:0]   vld_q;
    logic [CntW-1:0]      used_q, used_d;
    logic [CntW-1:0]      count_q, count_d;
    logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [DataWidth-1:0] mem_q [BufDepth];
    logic                 fire_in, fire_out, push, pop;

`ifdef FP_STREAM_ADAPTER_FLUSH_EN
    assign flush = flush_i;
`else
    assign flush = 1'b0;
`endif

    // The core sees the operand bus directly and runs every cycle.
    assign core_operand_o = in_data_i;

    // Credits cover in-flight ops plus buffered results. Readiness therefore
    // depends only on registers and never on out_ready_i.
    assign in_ready_o  = (used_q < DepthCnt) && !flush;
    assign fire_in     = in_valid_i && in_ready_o;
    assign out_valid_o = (count_q != '0);
    assign fire_out    = out_valid_o && out_ready_i;
    assign push        = vld_q[Latency-1];
    assign pop         = fire_out;
    assign out_data_o  = mem_q[rd_ptr_q];
    assign busy_o      = (used_q != '0);

    // Next-state logic for the credits, the FIFO count and the pointers.
    always_comb begin
        // NOTE: every output of this block is given a default first, so no
        // path leaves a variable unassigned and no latch is inferred.
        used_d   = used_q;
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            used_d   = '0;
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            case ({fire_in, fire_out})
                2'b10:   used_d = used_q + 1'b1;
                2'b01:   used_d = used_q - 1'b1;
                default: used_d = used_q;
            endcase
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
            if (push) wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;
        end
    end

    // Control state: the valid pipe, credits, count and pointers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        // NOTE: state registers use non-blocking assignments, so every
        // register samples pre-edge values no matter the statement order.
        if (!rst_ni) begin
            vld_q    <= '0;
            used_q   <= '0;
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            vld_q    <= flush ? '0 : ((vld_q << 1) | Latency'(fire_in));
            used_q   <= used_d;
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Result storage: capture the core output in the cycle its valid bit
    // reaches the end of the pipe.
    always_ff @(posedge clk_i) begin
        // NOTE: the storage array has no reset. The count gates every read,
        // so stale contents are never visible, and a reset would only cost
        // flops.
        if (push) mem_q[wr_ptr_q] <= core_result_i;
    end

    // The credit limit must keep every capture away from a full FIFO.
    assert property (@(posedge clk_i) disable iff (!rst_ni)
        (push && !pop && !flush) |-> (count_q != DepthCnt));

endmodule

// File: tb/tb_fp_stream_adapter.sv
// Testbench for fp_stream_adapter (Latency=2, BufDepth=4).
// The core model returns R = X+1 two cycles later. A scoreboard queue holds
// the expected results in issue order.
module tb_fp_stream_adapter;

    localparam int DW = 34;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          in_valid_i = 1'b0;
    logic          in_ready_o;
    logic [DW-1:0] in_data_i = '0;
    logic [DW-1:0] core_operand_o;
    logic [DW-1:0] core_result_i;
    logic          out_valid_o;
    logic          out_ready_i = 1'b0;
    logic [DW-1:0] out_data_o;
    logic          busy_o;
`ifdef FP_STREAM_ADAPTER_FLUSH_EN
    logic          flush_i = 1'b0;
`endif

    int pass_cnt  = 0;
    int total_cnt = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] core_d1, core_d2;

    fp_stream_adapter #(.DataWidth(DW), .Latency(2), .BufDepth(4)) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
`ifdef FP_STREAM_ADAPTER_FLUSH_EN
        .flush_i        (flush_i),
`endif
        .in_valid_i     (in_valid_i),
        .in_ready_o     (in_ready_o),
        .in_data_i      (in_data_i),
        .core_operand_o (core_operand_o),
        .core_result_i  (core_result_i),
        .out_valid_o    (out_valid_o),
        .out_ready_i    (out_ready_i),
        .out_data_o     (out_data_o),
        .busy_o         (busy_o)
    );

    always #5 clk_i = ~clk_i;

    // Core model: result is the operand plus one, two cycles later.
    always @(posedge clk_i) begin
        core_d1 <= core_operand_o + 34'd1;
        core_d2 <= core_d1;
    end
    assign core_result_i = core_d2;

    // Scoreboard: push on accepted operand, pop and compare on consumed result.
    always @(negedge clk_i) begin
        logic [DW-1:0] exp;
        if (rst_ni) begin
`ifdef FP_STREAM_ADAPTER_FLUSH_EN
            if (flush_i) exp_q.delete();
`endif
            if (in_valid_i && in_ready_o) exp_q.push_back(in_data_i + 34'd1);
            if (out_valid_o && out_ready_i) begin
                total_cnt++;
                if (exp_q.size() == 0) begin
                    $display("FAIL sb_unexpected: got %h, none expected", out_data_o);
                end else begin
                    exp = exp_q.pop_front();
                    if (out_data_o !== exp)
                        $display("FAIL sb_data: got %h, expected %h", out_data_o, exp);
                    else
                        pass_cnt++;
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        #3;
        total_cnt++; if (out_valid_o !== 1'b0) $display("FAIL rst_out_valid: got %b, expected 0", out_valid_o); else pass_cnt++;
        total_cnt++; if (busy_o !== 1'b0) $display("FAIL rst_busy: got %b, expected 0", busy_o); else pass_cnt++;
        total_cnt++; if (in_ready_o !== 1'b1) $display("FAIL rst_in_ready: got %b, expected 1", in_ready_o); else pass_cnt++;
        @(negedge clk_i);
        rst_ni = 1'b1;
        cyc();
    endtask

    task automatic test_single();
        in_valid_i = 1'b1; in_data_i = 34'h10; out_ready_i = 1'b1;
        @(negedge clk_i);
        total_cnt++; if (in_ready_o !== 1'b1) $display("FAIL single_ready: got %b, expected 1", in_ready_o); else pass_cnt++;
        cyc();
        in_valid_i = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk_i);
            total_cnt++; if (out_valid_o !== (c == 3)) $display("FAIL single_valid c%0d: got %b, expected %b", c, out_valid_o, (c == 3)); else pass_cnt++;
            total_cnt++; if (busy_o !== (c <= 3)) $display("FAIL single_busy c%0d: got %b, expected %b", c, busy_o, (c <= 3)); else pass_cnt++;
            if (c == 3) begin
                total_cnt++; if (out_data_o !== 34'h11) $display("FAIL single_data: got %h, expected 11", out_data_o); else pass_cnt++;
            end
            cyc();
        end
    endtask

    task automatic test_streaming();
        out_ready_i = 1'b1;
        for (int c = 0; c < 22; c++) begin
            if (c < 16) begin in_valid_i = 1'b1; in_data_i = 34'(c); end
            else in_valid_i = 1'b0;
            @(negedge clk_i);
            if (c < 16) begin
                total_cnt++; if (in_ready_o !== 1'b1) $display("FAIL stream_ready c%0d: got %b, expected 1", c, in_ready_o); else pass_cnt++;
            end
            total_cnt++; if (out_valid_o !== (c >= 3 && c <= 18)) $display("FAIL stream_valid c%0d: got %b, expected %b", c, out_valid_o, (c >= 3 && c <= 18)); else pass_cnt++;
            if (c >= 3 && c <= 18) begin
                total_cnt++; if (out_data_o !== 34'(c - 2)) $display("FAIL stream_data c%0d: got %h, expected %h", c, out_data_o, 34'(c - 2)); else pass_cnt++;
            end
            cyc();
        end
    endtask

    task automatic test_backpressure();
        int acc = 0;
        out_ready_i = 1'b0;
        for (int c = 0; c < 8; c++) begin
            in_valid_i = 1'b1; in_data_i = 34'(256 + c);
            @(negedge clk_i);
            if (in_valid_i && in_ready_o) acc++;
            total_cnt++; if (in_ready_o !== (c < 4)) $display("FAIL bp_ready c%0d: got %b, expected %b", c, in_ready_o, (c < 4)); else pass_cnt++;
            if (c >= 3) begin
                total_cnt++; if (out_valid_o !== 1'b1 || out_data_o !== 34'h101) $display("FAIL bp_hold c%0d: got %b/%h, expected 1/101", c, out_valid_o, out_data_o); else pass_cnt++;
            end
            cyc();
        end
        total_cnt++; if (acc !== 4) $display("FAIL bp_accepted: got %0d, expected 4", acc); else pass_cnt++;
        in_valid_i = 1'b0; out_ready_i = 1'b1;
        for (int d = 0; d < 6; d++) begin
            @(negedge clk_i);
            total_cnt++; if (out_valid_o !== (d < 4)) $display("FAIL bp_drain_valid d%0d: got %b, expected %b", d, out_valid_o, (d < 4)); else pass_cnt++;
            total_cnt++; if (in_ready_o !== (d >= 1)) $display("FAIL bp_drain_ready d%0d: got %b, expected %b", d, in_ready_o, (d >= 1)); else pass_cnt++;
            cyc();
        end
    endtask

    // Random issue and backpressure: captures coincide with pops at many counts.
    task automatic test_back_to_back();
        for (int c = 0; c < 60; c++) begin
            in_valid_i  = 1'($urandom_range(0, 1));
            in_data_i   = 34'({$urandom(), $urandom()});
            out_ready_i = 1'($urandom_range(0, 1));
            cyc();
        end
        in_valid_i = 1'b0; out_ready_i = 1'b1;
        repeat (8) cyc();
        @(negedge clk_i);
        total_cnt++; if (out_valid_o !== 1'b0 || busy_o !== 1'b0) $display("FAIL b2b_idle: got valid %b busy %b, expected 0 0", out_valid_o, busy_o); else pass_cnt++;
        total_cnt++; if (exp_q.size() != 0) $display("FAIL b2b_lost: got %0d pending, expected 0", exp_q.size()); else pass_cnt++;
        cyc();
    endtask

    task automatic test_reset_mid();
        out_ready_i = 1'b0;
        for (int c = 0; c < 3; c++) begin
            in_valid_i = 1'b1; in_data_i = 34'(512 + c);
            cyc();
        end
        in_valid_i = 1'b0;
        total_cnt++; if (out_valid_o !== 1'b1 || busy_o !== 1'b1) $display("FAIL rmid_setup: got valid %b busy %b, expected 1 1", out_valid_o, busy_o); else pass_cnt++;
        #1 rst_ni = 1'b0;
        #1;
        total_cnt++; if (out_valid_o !== 1'b0) $display("FAIL rmid_valid: got %b, expected 0", out_valid_o); else pass_cnt++;
        total_cnt++; if (busy_o !== 1'b0) $display("FAIL rmid_busy: got %b, expected 0", busy_o); else pass_cnt++;
        total_cnt++; if (in_ready_o !== 1'b1) $display("FAIL rmid_ready: got %b, expected 1", in_ready_o); else pass_cnt++;
        exp_q.delete();
        out_ready_i = 1'b1;
        @(negedge clk_i);
        #1 rst_ni = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk_i);
            total_cnt++; if (out_valid_o !== 1'b0) $display("FAIL rmid_stale c%0d: got %b, expected 0", c, out_valid_o); else pass_cnt++;
        end
        cyc();
    endtask

`ifdef FP_STREAM_ADAPTER_FLUSH_EN
    task automatic test_flush();
        out_ready_i = 1'b0;
        for (int c = 0; c < 3; c++) begin
            in_valid_i = 1'b1; in_data_i = 34'(768 + c);
            cyc();
        end
        flush_i = 1'b1; in_data_i = 34'h3FF;
        @(negedge clk_i);
        total_cnt++; if (in_ready_o !== 1'b0) $display("FAIL flush_ready: got %b, expected 0", in_ready_o); else pass_cnt++;
        cyc();
        flush_i = 1'b0; in_data_i = 34'h55; out_ready_i = 1'b1;
        for (int c = 4; c <= 8; c++) begin
            if (c > 4) in_valid_i = 1'b0;
            @(negedge clk_i);
            total_cnt++; if (out_valid_o !== (c == 7)) $display("FAIL flush_valid c%0d: got %b, expected %b", c, out_valid_o, (c == 7)); else pass_cnt++;
            if (c == 7) begin
                total_cnt++; if (out_data_o !== 34'h56) $display("FAIL flush_data: got %h, expected 56", out_data_o); else pass_cnt++;
            end
            cyc();
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_streaming();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
`ifdef FP_STREAM_ADAPTER_FLUSH_EN
        test_flush();
`endif
        repeat (4) cyc();
        total_cnt++; if (exp_q.size() != 0) $display("FAIL final_pending: got %0d, expected 0", exp_q.size()); else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
